// File: rtl/data_memory_writer.sv
// Byte-serial store engine over an internal byte array: SB/SH/SW stores are
// committed one byte per clock, with a registered little-endian word read port.
module data_memory_writer #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memoryWriteEnable,
  input  logic [31:0] memoryWriteAddr,
  input  logic [31:0] memoryWriteData,
  input  logic [2:0]  memoryWriteType,
  output logic        memoryWriteDone,
  input  logic [31:0] memoryReadAddr,
  output logic [31:0] memoryReadData,
  output logic        misalignedError
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  logic [7:0] mem [MEM_BYTES];

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    len_q, len_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req_ok_s;
  logic [2:0]    req_len_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic [7:0]    wr_byte_s;

  // decode store type into byte length and alignment legality
  always_comb begin
    req_ok_s  = 1'b0;
    req_len_s = 3'd0;
    case (memoryWriteType)
      3'b000: begin
        req_ok_s  = 1'b1;
        req_len_s = 3'd1;
      end
      3'b001: begin
        req_ok_s  = ~memoryWriteAddr[0];
        req_len_s = 3'd2;
      end
      3'b010: begin
        req_ok_s  = (memoryWriteAddr[1:0] == 2'b00);
        req_len_s = 3'd4;
      end
      default: begin
        req_ok_s  = 1'b0;
        req_len_s = 3'd0;
      end
    endcase
  end

  // next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (memoryWriteEnable) begin
          if (req_ok_s) begin
            addr_d  = memoryWriteAddr[AW-1:0];
            data_d  = memoryWriteData;
            len_d   = req_len_s;
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      WRITE: begin
        wr_en_s = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == (len_q - 3'd1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  // byte lane and target index of the byte being committed this cycle
  always_comb begin
    wr_idx_s = addr_q + AW'(cnt_q);
    case (cnt_q[1:0])
      2'd0:    wr_byte_s = data_q[7:0];
      2'd1:    wr_byte_s = data_q[15:8];
      2'd2:    wr_byte_s = data_q[23:16];
      2'd3:    wr_byte_s = data_q[31:24];
      default: wr_byte_s = 8'h00;
    endcase
  end

  // word read: upper address bits dropped, low two bits forced to the word base
  always_comb begin
    rdata_d = {mem[{memoryReadAddr[AW-1:2], 2'b11}],
               mem[{memoryReadAddr[AW-1:2], 2'b10}],
               mem[{memoryReadAddr[AW-1:2], 2'b01}],
               mem[{memoryReadAddr[AW-1:2], 2'b00}]};
  end

  // control and output registers; reset wins over any request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= 32'h0000_0000;
      len_q   <= 3'd0;
      cnt_q   <= 3'd0;
      done_q  <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // memory array is never reset; a reset edge aborts the pending byte
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem[wr_idx_s] <= wr_byte_s;
    end
  end

  assign memoryWriteDone = done_q;
  assign misalignedError = err_q;
  assign memoryReadData  = rdata_q;

endmodule

// File: tb/tb_data_memory_writer.sv
// Directed bench for data_memory_writer: one task per scenario, each with
// hand-computed expectations and inline comparisons.
module tb_data_memory_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memoryWriteEnable;
  logic [31:0] memoryWriteAddr;
  logic [31:0] memoryWriteData;
  logic [2:0]  memoryWriteType;
  logic        memoryWriteDone;
  logic [31:0] memoryReadAddr;
  logic [31:0] memoryReadData;
  logic        misalignedError;

  int checks = 0;
  int errors = 0;

  data_memory_writer #(.MEM_BYTES(1024)) dut (
    .clk              (clk),
    .reset            (reset),
    .memoryWriteEnable(memoryWriteEnable),
    .memoryWriteAddr  (memoryWriteAddr),
    .memoryWriteData  (memoryWriteData),
    .memoryWriteType  (memoryWriteType),
    .memoryWriteDone  (memoryWriteDone),
    .memoryReadAddr   (memoryReadAddr),
    .memoryReadData   (memoryReadData),
    .misalignedError  (misalignedError)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) dut.mem[i] = 8'h00;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-edge request pulse; returns just after the sampling edge
  task automatic start_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    memoryWriteType   = t;
    memoryWriteAddr   = a;
    memoryWriteData   = d;
    memoryWriteEnable = 1'b1;
    tick();
    memoryWriteEnable = 1'b0;
    memoryWriteData   = 32'h0BAD_F00D;
    memoryWriteAddr   = 32'h0000_0000;
  endtask

  // cycles done stays low, counted from the acceptance edge
  task automatic count_low(output int n);
    n = 0;
    while (memoryWriteDone === 1'b0 && n < 16) begin
      n++;
      tick();
    end
  endtask

  task automatic read_word(input logic [31:0] a, output logic [31:0] v);
    memoryReadAddr = a;
    tick();
    v = memoryReadData;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (memoryWriteDone !== 1'b1) begin
      errors++; $display("FAIL reset_done got %b want 1", memoryWriteDone);
    end
    checks++;
    if (misalignedError !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", misalignedError);
    end
    checks++;
    if (memoryReadData !== 32'h0000_0000) begin
      errors++; $display("FAIL reset_rdata got %h want 00000000", memoryReadData);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw();
    int n;
    logic [31:0] v;
    start_store(3'b010, 32'h0000_0010, 32'h1234_5678);
    count_low(n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL sw_done_low got %0d want 4", n);
    end
    checks++;
    if ({dut.mem[19], dut.mem[18], dut.mem[17], dut.mem[16]} !== 32'h1234_5678) begin
      errors++; $display("FAIL sw_bytes got %h%h%h%h want 12345678",
                         dut.mem[19], dut.mem[18], dut.mem[17], dut.mem[16]);
    end
    read_word(32'h0000_0010, v);
    checks++;
    if (v !== 32'h1234_5678) begin
      errors++; $display("FAIL sw_read got %h want 12345678", v);
    end
  endtask

  task automatic test_sb();
    int n;
    logic [31:0] v;
    start_store(3'b000, 32'h0000_0021, 32'hAABB_CCDD);
    count_low(n);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL sb_done_low got %0d want 1", n);
    end
    read_word(32'h0000_0020, v);
    checks++;
    if (v !== 32'h0000_DD00) begin
      errors++; $display("FAIL sb_read got %h want 0000dd00", v);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  types [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] addrs [3] = '{32'h0000_0031, 32'h0000_0042, 32'h0000_0070};
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      start_store(types[i], addrs[i], 32'hDEAD_BEEF);
      checks++;
      if (misalignedError !== 1'b1 || memoryWriteDone !== 1'b1) begin
        errors++; $display("FAIL reject_pulse[%0d] err %b done %b want err 1 done 1",
                           i, misalignedError, memoryWriteDone);
      end
      tick();
      checks++;
      if (misalignedError !== 1'b0 || memoryWriteDone !== 1'b1) begin
        errors++; $display("FAIL reject_clear[%0d] err %b done %b want err 0 done 1",
                           i, misalignedError, memoryWriteDone);
      end
      read_word(addrs[i], v);
      checks++;
      if (v !== 32'h0000_0000) begin
        errors++; $display("FAIL reject_nowrite[%0d] got %h want 00000000", i, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  exp_done = 6'b010000;
    logic [31:0] vals [6] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    int n;
    logic [31:0] v;
    memoryWriteType   = 3'b010;
    memoryWriteAddr   = 32'h0000_0050;
    memoryWriteEnable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      memoryWriteData = vals[i];
      tick();
      memoryWriteData = 32'h0000_0000;
      checks++;
      if (memoryWriteDone !== exp_done[i]) begin
        errors++; $display("FAIL b2b_done[%0d] got %b want %b", i, memoryWriteDone, exp_done[i]);
      end
    end
    memoryWriteEnable = 1'b0;
    count_low(n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL b2b_second_low got %0d want 4", n);
    end
    read_word(32'h0000_0050, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL b2b_read got %h want ffffffff", v);
    end
  endtask

  task automatic test_read_before_write();
    memoryReadAddr = 32'h0000_0010;
    start_store(3'b000, 32'h0000_0010, 32'h0000_0099);
    tick();
    checks++;
    if (memoryReadData !== 32'h1234_5678) begin
      errors++; $display("FAIL rbw_same_edge got %h want 12345678", memoryReadData);
    end
    tick();
    checks++;
    if (memoryReadData !== 32'h1234_5699) begin
      errors++; $display("FAIL rbw_after got %h want 12345699", memoryReadData);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v;
    start_store(3'b010, 32'h0000_0060, 32'h1122_3344);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (memoryWriteDone !== 1'b1 || memoryReadData !== 32'h0000_0000) begin
      errors++; $display("FAIL abort_state done %b rdata %h want done 1 rdata 00000000",
                         memoryWriteDone, memoryReadData);
    end
    tick();
    tick();
    read_word(32'h0000_0060, v);
    checks++;
    if (v !== 32'h0000_3344) begin
      errors++; $display("FAIL abort_read got %h want 00003344", v);
    end
    read_word(32'h0000_0010, v);
    checks++;
    if (v !== 32'h1234_5699) begin
      errors++; $display("FAIL abort_mem_kept got %h want 12345699", v);
    end
  endtask

  task automatic test_alias();
    int n;
    logic [31:0] v;
    start_store(3'b010, 32'h0000_0400, 32'hCAFE_BABE);
    count_low(n);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL alias_done_low got %0d want 4", n);
    end
    read_word(32'h0000_0800, v);
    checks++;
    if (v !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL alias_read800 got %h want cafebabe", v);
    end
    read_word(32'h0000_0000, v);
    checks++;
    if (v !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL alias_read000 got %h want cafebabe", v);
    end
  endtask

  initial begin
    reset             = 1'b1;
    memoryWriteEnable = 1'b0;
    memoryWriteAddr   = 32'h0000_0000;
    memoryWriteData   = 32'h0000_0000;
    memoryWriteType   = 3'b000;
    memoryReadAddr    = 32'h0000_0000;
    test_reset();
    test_sw();
    test_sb();
    test_misaligned();
    test_back_to_back();
    test_read_before_write();
    test_reset_abort();
    test_alias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_writer.md
DATA_MEMORY_WRITER -- requirements
Module: data_memory_writer

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning internal byte-array size (power of two); byte index = addr mod MEM_BYTES.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port memoryWriteEnable  input  1  store-commit request, sampled each rising edge.
REQ-005 SHALL have port memoryWriteAddr  input  32  byte address of store.
REQ-006 SHALL have port memoryWriteData  input  32  store data; the low bytes are used per type.
REQ-007 SHALL have port memoryWriteType  input  3  000 SB, 001 SH, 010 SW; others invalid.
REQ-008 SHALL have port memoryWriteDone  output  1  high = idle, ready for a request; low = store in progress.
REQ-009 SHALL have port memoryReadAddr  input  32  byte address for word read.
REQ-010 SHALL have port memoryReadData  output  32  registered little-endian word read.
REQ-011 SHALL have port misalignedError  output  1  one-cycle pulse on rejected request.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, WRITE.
REQ-013 In IDLE, memoryWriteEnable=1 at a rising edge with a valid, aligned request SHALL latch addr, data and length (SB 1, SH 2, SW 4), clear byte counter, set memoryWriteDone=0, and enter WRITE.
REQ-014 In WRITE, each rising edge SHALL write byte[cnt] of the latched data (bits 8*cnt+7:8*cnt) to mem[(addr+cnt) mod MEM_BYTES], then increment cnt.
REQ-015 On the edge that writes the final byte (cnt = length-1), the block SHALL return to IDLE and set memoryWriteDone=1.
REQ-016 memoryWriteDone SHALL be low for exactly length cycles per accepted store: SB 1, SH 2, SW 4.
REQ-017 memoryWriteEnable SHALL be ignored while in WRITE, including on the final-byte edge; a request still high on the next edge is accepted then.
REQ-018 Latched request fields SHALL NOT change during WRITE, regardless of input changes.
REQ-019 A request with SH and addr[0]=1, with SW and addr[1:0]!=00, or with an invalid type SHALL be rejected: no byte written, state stays IDLE, memoryWriteDone stays 1, misalignedError=1 for that single following cycle.
REQ-020 misalignedError SHALL otherwise be 0.
REQ-021 Every rising edge SHALL load memoryReadData = {mem[w+3],mem[w+2],mem[w+1],mem[w]}, where w = (memoryReadAddr mod MEM_BYTES) with bits [1:0] forced to 00.
REQ-022 A read and a byte write to the same word on the same edge SHALL return the pre-write byte value (read-before-write).
REQ-023 Address bits above log2(MEM_BYTES) SHALL be ignored; address MEM_BYTES+k SHALL alias byte k.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, memoryWriteDone=1, misalignedError=0, memoryReadData=0, and cnt=0, with priority over any request.
REQ-025 Reset mid-WRITE SHALL abort the store: already-written bytes are kept and remaining bytes are not written.
REQ-026 Reset SHALL NOT clear memory contents; bench preloads the memory via a hierarchical initial block.

Verification
REQ-027 SW 0x12345678 to addr 0x10 -> done low for 4 cycles; mem[0x10..0x13] = 78,56,34,12; read 0x10 the next edge -> 0x12345678.
REQ-028 SB 0xAABBCCDD to addr 0x21 over word 0x00000000 -> done low 1 cycle; read 0x20 -> 0x0000DD00.
REQ-029 SH to addr 0x31, and SW to addr 0x42 -> no write, misalignedError pulses once each, done stays 1; type 011 -> same rejection.
REQ-030 SW 0xFFFFFFFF to 0x50 with memoryWriteEnable held high 6 cycles -> exactly one store accepted; a second store is accepted on the edge after done rises.
REQ-031 Reset asserted 2 cycles after accepting SW 0x11223344 at 0x60 over zeros -> read 0x60 -> 0x00003344; done=1 the cycle after reset.
REQ-032 SW 0xCAFEBABE to addr 0x400 (MEM_BYTES=1024) -> bytes land at 0x000..0x003; read 0x800 -> 0xCAFEBABE.
